// File: rtl/err_event_monitor.sv
// Error/status line monitor: edge detect, sticky flags, saturating counters, first-error capture, timestamped reports.
// Latency: flags/counters/first capture 1 cycle after a rise; report 2 cycles. Report register holds while rpt_ready_i=0.
module err_event_monitor #(
    parameter int NumCh = 9,
    parameter int CntW  = 8,
    parameter int TimeW = 32,
    localparam int IdxW = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [NumCh-1:0]      err_i,
    input  logic                  clr_i,
    input  logic [NumCh-1:0]      clr_mask_i,
    output logic [NumCh-1:0]      errored_o,
    output logic                  any_err_o,
    output logic [NumCh*CntW-1:0] cnt_o,
    output logic                  first_valid_o,
    output logic [IdxW-1:0]       first_idx_o,
    output logic                  rpt_valid_o,
    input  logic                  rpt_ready_i,
    output logic [IdxW-1:0]       rpt_idx_o,
    output logic [TimeW-1:0]      rpt_time_o,
    output logic [TimeW-1:0]      time_o
);

    logic [NumCh-1:0]           err_q;
    logic [NumCh-1:0]           errored_q;
    logic [NumCh-1:0]           pending_q;
    logic [NumCh-1:0][CntW-1:0] cnt_q;
    logic [TimeW-1:0]           stamp_q [NumCh];
    logic [TimeW-1:0]           time_q;
    logic                       first_valid_q;
    logic [IdxW-1:0]            first_idx_q;
    logic                       rpt_valid_q;
    logic [IdxW-1:0]            rpt_idx_q;
    logic [TimeW-1:0]           rpt_time_q;

    logic [NumCh-1:0] rise;
    logic [NumCh-1:0] clr_sel;
    logic [NumCh-1:0] first_occ;
    logic [NumCh-1:0] pend_oh;
    logic [NumCh-1:0] pend_take;
    logic             clr_all;
    logic             rpt_load;
    logic [IdxW-1:0]  pend_idx;
    logic [TimeW-1:0] pend_stamp;
    logic [IdxW-1:0]  rise_idx;

    assign rise     = err_i & ~err_q & {NumCh{en_i}};
    assign clr_sel  = clr_mask_i & {NumCh{clr_i}};
    assign clr_all  = clr_i & (&clr_mask_i);
    // A channel cleared in the same cycle it rises counts as a fresh first occurrence.
    assign first_occ = rise & (~errored_q | clr_sel);
    assign rpt_load  = (~rpt_valid_q | rpt_ready_i) & (|pending_q);
    assign pend_take = rpt_load ? pend_oh : '0;

    always_comb begin
        pend_idx   = '0;
        pend_stamp = '0;
        pend_oh    = '0;
        rise_idx   = '0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pend_idx    = IdxW'(i);
                pend_stamp  = stamp_q[i];
                pend_oh     = '0;
                pend_oh[i]  = 1'b1;
            end
            if (rise[i]) begin
                rise_idx = IdxW'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            time_q    <= '0;
            err_q     <= '0;
            errored_q <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
            for (int e = 0; e < NumCh; e++) begin
                stamp_q[e] <= '0;
            end
        end else begin
            time_q    <= time_q + TimeW'(1);
            err_q     <= err_i;
            errored_q <= (errored_q & ~clr_sel) | first_occ;
            pending_q <= (pending_q & ~pend_take & ~clr_sel) | first_occ;
            for (int e = 0; e < NumCh; e++) begin
                if (rise[e]) begin
                    if (clr_sel[e]) begin
                        cnt_q[e] <= CntW'(1);
                    end else if (cnt_q[e] != {CntW{1'b1}}) begin
                        cnt_q[e] <= cnt_q[e] + CntW'(1);
                    end
                end else if (clr_sel[e]) begin
                    cnt_q[e] <= '0;
                end
                if (first_occ[e]) begin
                    stamp_q[e] <= time_q;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
        end else if ((~first_valid_q | clr_all) & (|rise)) begin
            first_valid_q <= 1'b1;
            first_idx_q   <= rise_idx;
        end else if (clr_all) begin
            first_valid_q <= 1'b0;
        end
    end

    // Held report stays put until accepted, regardless of newer lower-index pendings.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rpt_valid_q <= 1'b0;
            rpt_idx_q   <= '0;
            rpt_time_q  <= '0;
        end else if (rpt_load) begin
            rpt_valid_q <= 1'b1;
            rpt_idx_q   <= pend_idx;
            rpt_time_q  <= pend_stamp;
        end else if (rpt_ready_i) begin
            rpt_valid_q <= 1'b0;
        end
    end

    assign errored_o     = errored_q;
    assign any_err_o     = |errored_q;
    assign cnt_o         = cnt_q;
    assign first_valid_o = first_valid_q;
    assign first_idx_o   = first_idx_q;
    assign rpt_valid_o   = rpt_valid_q;
    assign rpt_idx_o     = rpt_idx_q;
    assign rpt_time_o    = rpt_time_q;
    assign time_o        = time_q;

endmodule

// File: tb/tb_err_event_monitor.sv
// Randomized and directed bench for err_event_monitor with a reference model and report scoreboard.
module tb_err_event_monitor;

    localparam int NCH = 9;
    localparam int CW  = 8;
    localparam int TW  = 32;
    localparam int IW  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [NCH-1:0]  err;
    logic            clr;
    logic [NCH-1:0]  clr_mask;
    logic [NCH-1:0]  errored_o;
    logic            any_err_o;
    logic [NCH*CW-1:0] cnt_o;
    logic            first_valid_o;
    logic [IW-1:0]   first_idx_o;
    logic            rpt_valid_o;
    logic            rpt_ready;
    logic [IW-1:0]   rpt_idx_o;
    logic [TW-1:0]   rpt_time_o;
    logic [TW-1:0]   time_o;

    err_event_monitor #(.NumCh(NCH), .CntW(CW), .TimeW(TW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .err_i(err), .clr_i(clr),
        .clr_mask_i(clr_mask), .errored_o(errored_o), .any_err_o(any_err_o),
        .cnt_o(cnt_o), .first_valid_o(first_valid_o), .first_idx_o(first_idx_o),
        .rpt_valid_o(rpt_valid_o), .rpt_ready_i(rpt_ready), .rpt_idx_o(rpt_idx_o),
        .rpt_time_o(rpt_time_o), .time_o(time_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_acc = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: channel-level bookkeeping with plain arrays.
    logic [TW-1:0] m_time;
    bit            m_prev[NCH];
    bit            m_flag[NCH];
    bit            m_pend[NCH];
    int            m_cnt[NCH];
    logic [TW-1:0] m_stamp[NCH];
    bit            m_fv;
    int            m_fidx;
    bit            m_rv;
    int            m_ridx;
    logic [TW-1:0] m_rtime;
    logic [IW+TW-1:0] exp_q[$];

    initial begin
        m_time = '0; m_fv = 0; m_fidx = 0; m_rv = 0; m_ridx = 0; m_rtime = '0;
        for (int e = 0; e < NCH; e++) begin
            m_prev[e] = 0; m_flag[e] = 0; m_pend[e] = 0; m_cnt[e] = 0; m_stamp[e] = '0;
        end
    end

    always @(posedge clk) begin
        bit rose[NCH];
        int p;
        bit all_clr;
        if (!rst_n) begin
            m_time = '0; m_fv = 0; m_fidx = 0; m_rv = 0; m_ridx = 0; m_rtime = '0;
            for (int e = 0; e < NCH; e++) begin
                m_prev[e] = 0; m_flag[e] = 0; m_pend[e] = 0; m_cnt[e] = 0; m_stamp[e] = '0;
            end
            exp_q.delete();
        end else begin
            for (int e = 0; e < NCH; e++) rose[e] = en && err[e] && !m_prev[e];
            p = -1;
            for (int e = NCH - 1; e >= 0; e--) if (m_pend[e]) p = e;
            if ((!m_rv || rpt_ready) && p >= 0) begin
                m_rv = 1; m_ridx = p; m_rtime = m_stamp[p]; m_pend[p] = 0;
                exp_q.push_back({IW'(p), m_stamp[p]});
            end else if (rpt_ready) begin
                m_rv = 0;
            end
            all_clr = clr && (clr_mask == '1);
            if (clr) begin
                for (int e = 0; e < NCH; e++)
                    if (clr_mask[e]) begin m_flag[e] = 0; m_cnt[e] = 0; m_pend[e] = 0; end
                if (all_clr) m_fv = 0;
            end
            for (int e = 0; e < NCH; e++) begin
                if (rose[e]) begin
                    if (m_cnt[e] < (1 << CW) - 1) m_cnt[e]++;
                    if (!m_flag[e]) begin m_flag[e] = 1; m_pend[e] = 1; m_stamp[e] = m_time; end
                end
            end
            if (!m_fv) begin
                for (int e = NCH - 1; e >= 0; e--) if (rose[e]) begin m_fv = 1; m_fidx = e; end
            end
            for (int e = 0; e < NCH; e++) m_prev[e] = err[e];
            m_time = m_time + 1;
        end
    end

    // Monitor: compares outputs against the model and pops the scoreboard on each accepted report.
    bit            hold = 0;
    logic [IW-1:0] hold_idx;
    logic [TW-1:0] hold_time;

    always @(negedge clk) begin
        logic [NCH-1:0] mflags;
        logic [IW+TW-1:0] e_rpt;
        for (int e = 0; e < NCH; e++) mflags[e] = m_flag[e];
        chk("errored", errored_o, mflags);
        chk("any_err", any_err_o, |mflags);
        for (int e = 0; e < NCH; e++)
            chk($sformatf("cnt%0d", e), cnt_o[e*CW +: CW], m_cnt[e]);
        chk("first_valid", first_valid_o, m_fv);
        chk("first_idx", first_idx_o, m_fidx);
        chk("time", time_o, m_time);
        chk("rpt_valid", rpt_valid_o, m_rv);
        if (hold && rst_n) begin
            chk("rpt_hold_valid", rpt_valid_o, 1);
            chk("rpt_hold_idx", rpt_idx_o, hold_idx);
            chk("rpt_hold_time", rpt_time_o, hold_time);
        end
        hold = 0;
        if (rst_n && rpt_valid_o) begin
            if (rpt_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    chk("rpt_unexpected", 1, 0);
                end else begin
                    e_rpt = exp_q.pop_front();
                    chk("rpt_idx", rpt_idx_o, e_rpt[IW+TW-1:TW]);
                    chk("rpt_time", rpt_time_o, e_rpt[TW-1:0]);
                end
            end else begin
                hold = 1; hold_idx = rpt_idx_o; hold_time = rpt_time_o;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int acc0;
        logic [TW-1:0] t_saved;
        rst_n = 1'b0; en = 1'b1; err = '0; clr = 1'b0; clr_mask = '0; rpt_ready = 1'b1;
        step(3);
        chk("reset_errored", errored_o, 0);
        chk("reset_cnt", cnt_o, 0);
        chk("reset_time", time_o, 0);
        chk("reset_rpt_valid", rpt_valid_o, 0);
        rst_n = 1'b1;

        // 1: single pulse on ch3 rising at time 10
        for (int i = 0; i < 100 && time_o != 10; i++) step();
        chk("t1_time", time_o, 10);
        err = 9'h008;
        step();
        err = '0;
        chk("t1_errored", errored_o, 9'h008);
        chk("t1_cnt3", cnt_o[3*CW +: CW], 1);
        chk("t1_first_idx", first_idx_o, 3);
        step();
        chk("t1_rpt_valid", rpt_valid_o, 1);
        chk("t1_rpt_idx", rpt_idx_o, 3);
        chk("t1_rpt_time", rpt_time_o, 10);
        step();
        chk("t1_rpt_once", rpt_valid_o, 0);

        // 2: modulated ch0, 5 pulses
        do_reset();
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            err = 9'h001; step(2);
            err = '0;     step(2);
        end
        step(3);
        chk("t2_cnt0", cnt_o[0 +: CW], 5);
        chk("t2_errored", errored_o, 9'h001);
        chk("t2_reports", n_acc - acc0, 1);

        // 3: simultaneous ch2/ch5 with back-pressure
        do_reset();
        rpt_ready = 1'b0;
        err = 9'h024;
        step();
        err = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("t3_rpt_idx_held", rpt_idx_o, 2);
            step();
        end
        t_saved = rpt_time_o;
        rpt_ready = 1'b1;
        step();
        chk("t3_rpt_next_idx", rpt_idx_o, 5);
        chk("t3_rpt_same_time", rpt_time_o, t_saved);
        chk("t3_first_idx", first_idx_o, 2);
        step(2);

        // 4: saturation on ch7
        do_reset();
        acc0 = n_acc;
        for (int i = 0; i < 300; i++) begin
            err = 9'h080; step();
            err = '0;     step();
        end
        step(2);
        chk("t4_cnt7", cnt_o[7*CW +: CW], 255);
        chk("t4_reports", n_acc - acc0, 1);

        // 5: clear-all coinciding with a rise on ch1, then disabled pulses
        do_reset();
        err = 9'h1FF; step();
        err = '0;     step();
        chk("t5_all_flagged", errored_o, 9'h1FF);
        err = 9'h002; clr = 1'b1; clr_mask = 9'h1FF;
        step();
        clr = 1'b0; clr_mask = '0; err = '0;
        chk("t5_errored", errored_o, 9'h002);
        chk("t5_cnt", cnt_o, 72'h1 << CW);
        chk("t5_first_valid", first_valid_o, 1);
        chk("t5_first_idx", first_idx_o, 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            err = 9'h010; step();
            err = '0;     step();
        end
        chk("t5_disabled_errored", errored_o, 9'h002);
        chk("t5_disabled_cnt4", cnt_o[4*CW +: CW], 0);
        en = 1'b1;
        step(12);

        // 6: reset with held report and pending channels
        rpt_ready = 1'b0;
        err = 9'h0A8; step();
        err = '0;     step(3);
        rst_n = 1'b0; step();
        chk("t6_errored", errored_o, 0);
        chk("t6_rpt_valid", rpt_valid_o, 0);
        chk("t6_time", time_o, 0);
        chk("t6_first_valid", first_valid_o, 0);
        rst_n = 1'b1; rpt_ready = 1'b1;
        step(5);
        chk("t6_no_stale", rpt_valid_o, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            for (int e = 0; e < NCH; e++)
                if ($urandom_range(3) == 0) err[e] = ~err[e];
            en        = ($urandom_range(9) != 0);
            rpt_ready = ($urandom_range(2) != 0);
            clr       = ($urandom_range(29) == 0);
            clr_mask  = ($urandom_range(1) == 0) ? 9'h1FF : 9'($urandom);
            rst_n     = ($urandom_range(499) != 0);
            step();
        end
        rst_n = 1'b1; en = 1'b0; clr = 1'b0; rpt_ready = 1'b1; err = '0;
        step(20);
        chk("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
